density_renderer: RTL and testbench
===================================

DENSITY_RENDERER -- requirements
Module: density_renderer

Interface
REQ-001 The block SHALL have a single clock, pixel_clk_in, and a synchronous, active-high reset, rst_in.
REQ-002 It SHALL take these parameters, one per line (name, default, meaning):
- GRID_W, 205, cells per row.
- GRID_H, 155, rows of cells.
- CELL_SHIFT, 2, log2 of the square cell size in pixels.
- TAPS, 9, density taps per cell.
- DATA_W, 8, tap width.
- BRAM_LATENCY, 2, read latency in cycles.
- BRAM_DEPTH, GRID_W*GRID_H, memory depth.
REQ-003 It SHALL have these ports, one per line (name, direction, width, meaning):
- pixel_clk_in, in, 1, pixel clock.
- rst_in, in, 1, synchronous reset.
- hcount_in, in, 11, pixel column.
- vcount_in, in, 10, pixel row.
- mode_in, in, 2, colour mode request.
- overlay_in, in, 1, pink test overlay.
- data_in, in, TAPS x DATA_W, BRAM taps.
- addr_out, out, clog2(BRAM_DEPTH), BRAM address.
- red_out, out, 8, red.
- green_out, out, 8, green.
- blue_out, out, 8, blue.
- hcount_out, out, 11, aligned hcount.
- vcount_out, out, 10, aligned vcount.

Function
REQ-004 Stage A SHALL register addr_out = (hcount_in>>CELL_SHIFT) + row_base, where row_base is an accumulator (no multiplier).
- At hcount_in==0 && vcount_in==0: row_base is cleared to 0.
- At hcount_in==0, when vcount_in[CELL_SHIFT-1:0]==0 and vcount_in!=0: row_base += GRID_W.
REQ-005 A pixel SHALL be out of bounds when (hcount_in>>CELL_SHIFT) >= GRID_W or (vcount_in>>CELL_SHIFT) >= GRID_H; for such a pixel addr_out is 0 and an oob flag is carried down the pipeline.
REQ-006 hcount, vcount, oob and the overlay bit SHALL pass through a delay line of BRAM_LATENCY+1 stages, so that they align with data_in.
REQ-007 The colour stage SHALL register RGB and the aligned counts, giving a total latency of BRAM_LATENCY+2 cycles (4 at defaults) from hcount_in to red_out and hcount_out.
REQ-008 sum SHALL be the unsigned sum of all taps, of width SUM_W = clog2(TAPS*(2^DATA_W-1)+1), with no overflow (12 bits at defaults).
REQ-009 A cell SHALL be a barrier when every tap equals 2^DATA_W-1.
REQ-010 Output priority SHALL be: oob or barrier gives 0,0,0; otherwise overlay gives 219,48,130; otherwise the active mode applies.
REQ-011 Mode 0, PACKED, SHALL output red={sum[11:8],4'b0}, green={sum[7:4],4'b0}, blue={sum[3:0],4'b0}, using the top 12 bits of sum zero-extended when SUM_W<12.
REQ-012 Mode 1, GRAY, SHALL set r=g=b=t, where t = sum[SUM_W-1:SUM_W-8].
REQ-013 Mode 2, HEAT, SHALL output red=t, blue=255-t, green=(t[7] ? 255-t : t)<<1, truncated to 8 bits.
REQ-014 Mode 3, CENTER, SHALL set r=g=b=data_in[TAPS/2], zero-extended or truncated to 8 bits.
REQ-015 The active mode SHALL be loaded from mode_in only in the cycle with hcount_in==0 && vcount_in==0, so that there is no mid-frame tearing; pixels already in the pipeline use the mode active when they reached the colour stage.

Reset
REQ-016 On rst_in the following SHALL all be cleared to 0:
- addr_out, RGB outputs, hcount_out and vcount_out;
- row_base, the delay line and the oob flags;
- the active mode (PACKED).
REQ-017 Reset mid-frame SHALL produce black for BRAM_LATENCY+2 cycles after release; addressing SHALL be correct from the next frame start.

Configuration
REQ-018 With DENSITY_GRID_LINES_EN defined, an in-bounds non-barrier pixel whose hcount or vcount low CELL_SHIFT bits are all zero SHALL output 64,64,64, ranking below overlay and above mode.
REQ-019 Without DENSITY_GRID_LINES_EN, the grid-line logic SHALL be absent and the priority SHALL be exactly as in REQ-010.

Structure
REQ-020 Package density_pkg SHALL hold:
- the mode enum (PACKED, GRAY, HEAT, CENTER);
- the overlay and grid-line colour constants;
- the grid default constants.
REQ-021 Sub-module density_sum SHALL be the combinational TAPS-input adder tree plus the barrier detect.

Verification
REQ-022 The bench SHALL cover these directed scenarios (default parameters):
- Scan pixel (8,12): addr_out=2+3*205=617 one cycle later; data_in all 10 after 2 more cycles; PACKED output 0,80,160 (sum 90) at cycle 4 with hcount_out=8.
- Pixel (820,0) or (0,620): addr_out=0 and RGB=0,0,0 regardless of data_in.
- All taps 255: output black; then overlay_in=1 still gives black; taps all 0 with overlay gives 219,48,130.
- mode_in changed to HEAT mid-frame: output unchanged until after the next (0,0); then all taps 255 except one at 0 (sum 2040, t=127) gives 127,254,128.
- rst_in asserted at pixel (400,300): next 4 outputs black; the next frame's address at (0,4) is 205.
- With DENSITY_GRID_LINES_EN defined: pixel (4,5) with sum 90 gives 64,64,64; pixel (5,5) gives the PACKED colour.

Source files
------------

// File: rtl/density_pkg.sv
// Shared definitions for the density renderer: colour modes, fixed colours
// and the default grid geometry.
package density_pkg;

    // Colour mode selected once per frame
    typedef enum logic [1:0] {
        PACKED = 2'd0,
        GRAY   = 2'd1,
        HEAT   = 2'd2,
        CENTER = 2'd3
    } mode_e;

    // Pink test overlay colour
    localparam logic [7:0] OVERLAY_R = 8'd219;
    localparam logic [7:0] OVERLAY_G = 8'd48;
    localparam logic [7:0] OVERLAY_B = 8'd130;

    // Grey level used for cell-boundary grid lines
    localparam logic [7:0] GRID_LINE_LEVEL = 8'd64;

    // Default grid geometry and memory timing
    localparam int DEF_GRID_W       = 205;
    localparam int DEF_GRID_H       = 155;
    localparam int DEF_CELL_SHIFT   = 2;
    localparam int DEF_TAPS         = 9;
    localparam int DEF_DATA_W       = 8;
    localparam int DEF_BRAM_LATENCY = 2;

    // Width needed to hold the sum of every tap at full scale
    function automatic int sum_width(input int taps, input int data_w);
        return $clog2(taps * ((1 << data_w) - 1) + 1);
    endfunction

endpackage

// File: rtl/density_sum.sv
// Combinational sum of all density taps of one cell, plus detection of a
// barrier cell (every tap at full scale).
module density_sum #(
    parameter int TAPS   = 9,
    parameter int DATA_W = 8,
    parameter int SUM_W  = 12
) (
    input  logic [TAPS*DATA_W-1:0] i_taps,
    output logic [SUM_W-1:0]       o_sum,
    output logic                   o_barrier
);

    // Add every tap (width chosen so the total can never overflow) and
    // clear the barrier flag as soon as any tap is below full scale
    always_comb begin
        o_sum     = '0;
        o_barrier = 1'b1;
        for (int i = 0; i < TAPS; i++) begin
            o_sum = o_sum + SUM_W'(i_taps[i*DATA_W +: DATA_W]);
            if (i_taps[i*DATA_W +: DATA_W] != {DATA_W{1'b1}}) begin
                o_barrier = 1'b0;
            end
        end
    end

endmodule

// File: rtl/density_renderer.sv
// Density field renderer: turns the pixel scan position into a cell address,
// waits out the memory latency, then colours the cell from its density taps.
// Optional build macro: DENSITY_GRID_LINES_EN draws grey lines on cell edges.
// Latency from hcount_in to the RGB/count outputs is BRAM_LATENCY+2 cycles.
module density_renderer
    import density_pkg::*;
#(
    parameter int GRID_W       = DEF_GRID_W,
    parameter int GRID_H       = DEF_GRID_H,
    parameter int CELL_SHIFT   = DEF_CELL_SHIFT,
    parameter int TAPS         = DEF_TAPS,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int BRAM_LATENCY = DEF_BRAM_LATENCY,
    parameter int BRAM_DEPTH   = GRID_W * GRID_H
) (
    input  logic                          pixel_clk_in,
    input  logic                          rst_in,
    input  logic [10:0]                   hcount_in,
    input  logic [9:0]                    vcount_in,
    input  logic [1:0]                    mode_in,
    input  logic                          overlay_in,
    input  logic [TAPS*DATA_W-1:0]        data_in,
    output logic [$clog2(BRAM_DEPTH)-1:0] addr_out,
    output logic [7:0]                    red_out,
    output logic [7:0]                    green_out,
    output logic [7:0]                    blue_out,
    output logic [10:0]                   hcount_out,
    output logic [9:0]                    vcount_out
);

    localparam int ADDR_W = $clog2(BRAM_DEPTH);
    localparam int SUM_W  = sum_width(TAPS, DATA_W);
    localparam int DLY    = BRAM_LATENCY + 1;

    localparam logic [10:0] GRID_W_H = 11'(GRID_W);
    localparam logic [9:0]  GRID_H_V = 10'(GRID_H);

    // ---------------- Stage A: address generation ----------------
    logic [ADDR_W-1:0] r_row_base;
    logic [ADDR_W-1:0] w_row_base;
    logic [10:0]       w_hcell;
    logic [9:0]        w_vcell;
    logic              w_frame_start;
    logic              w_row_step;
    logic              w_oob;
    logic [ADDR_W-1:0] w_addr;

    assign w_hcell       = hcount_in >> CELL_SHIFT;
    assign w_vcell       = vcount_in >> CELL_SHIFT;
    assign w_frame_start = (hcount_in == '0) && (vcount_in == '0);
    assign w_row_step    = (hcount_in == '0) && (vcount_in[CELL_SHIFT-1:0] == '0)
                           && (vcount_in != '0);
    assign w_oob         = (w_hcell >= GRID_W_H) || (w_vcell >= GRID_H_V);

    // Row base used by this pixel: the first pixel of a new cell row already
    // sees the advanced base, so no multiplier is needed for the address
    always_comb begin
        w_row_base = r_row_base;
        if (w_frame_start) begin
            w_row_base = '0;
        end else if (w_row_step) begin
            w_row_base = r_row_base + ADDR_W'(GRID_W);
        end
    end

    assign w_addr = w_oob ? '0 : (ADDR_W'(w_hcell) + w_row_base);

    // Register the memory address and keep the row accumulator
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            r_row_base <= '0;
            addr_out   <= '0;
        end else begin
            r_row_base <= w_row_base;
            addr_out   <= w_addr;
        end
    end

    // ---------------- Frame-synchronous mode ----------------
    mode_e r_mode;

    // Latch the requested mode only at frame start to avoid tearing
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            r_mode <= PACKED;
        end else if (w_frame_start) begin
            r_mode <= mode_e'(mode_in);
        end
    end

    // ---------------- Delay line aligned with memory data ----------------
    // A valid bit rides along so the stages flushed by reset render black.
    logic [10:0] r_dly_h   [DLY];
    logic [9:0]  r_dly_v   [DLY];
    logic        r_dly_oob [DLY];
    logic        r_dly_ov  [DLY];
    logic        r_dly_vld [DLY];

    // Shift pixel attributes so they meet data_in for the same cell
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < DLY; i++) begin
                r_dly_h[i]   <= '0;
                r_dly_v[i]   <= '0;
                r_dly_oob[i] <= 1'b0;
                r_dly_ov[i]  <= 1'b0;
                r_dly_vld[i] <= 1'b0;
            end
        end else begin
            r_dly_h[0]   <= hcount_in;
            r_dly_v[0]   <= vcount_in;
            r_dly_oob[0] <= w_oob;
            r_dly_ov[0]  <= overlay_in;
            r_dly_vld[0] <= 1'b1;
            for (int i = 1; i < DLY; i++) begin
                r_dly_h[i]   <= r_dly_h[i-1];
                r_dly_v[i]   <= r_dly_v[i-1];
                r_dly_oob[i] <= r_dly_oob[i-1];
                r_dly_ov[i]  <= r_dly_ov[i-1];
                r_dly_vld[i] <= r_dly_vld[i-1];
            end
        end
    end

    // ---------------- Colour stage ----------------
    logic [SUM_W-1:0] w_sum;
    logic             w_barrier;
    logic [11:0]      w_p12;
    logic [7:0]       w_t;
    logic [7:0]       w_fold;
    logic [7:0]       w_center;
    logic [7:0]       w_red;
    logic [7:0]       w_green;
    logic [7:0]       w_blue;

    density_sum #(
        .TAPS   (TAPS),
        .DATA_W (DATA_W),
        .SUM_W  (SUM_W)
    ) u_sum (
        .i_taps    (data_in),
        .o_sum     (w_sum),
        .o_barrier (w_barrier)
    );

    assign w_t    = w_sum[SUM_W-1 -: 8];
    assign w_fold = w_t[7] ? ~w_t : w_t;

    generate
        if (SUM_W >= 12) begin : g_packed_top
            assign w_p12 = w_sum[SUM_W-1 -: 12];
        end else begin : g_packed_ext
            assign w_p12 = {{(12-SUM_W){1'b0}}, w_sum};
        end
        if (DATA_W >= 8) begin : g_center_trunc
            assign w_center = data_in[(TAPS/2)*DATA_W +: 8];
        end else begin : g_center_ext
            assign w_center = {{(8-DATA_W){1'b0}}, data_in[(TAPS/2)*DATA_W +: DATA_W]};
        end
    endgenerate

`ifdef DENSITY_GRID_LINES_EN
    logic w_grid;
    assign w_grid = (r_dly_h[DLY-1][CELL_SHIFT-1:0] == '0)
                    || (r_dly_v[DLY-1][CELL_SHIFT-1:0] == '0);
`endif

    // Pick the pixel colour: black, overlay, optional grid line, then mode
    always_comb begin
        w_red   = 8'd0;
        w_green = 8'd0;
        w_blue  = 8'd0;
        if (!r_dly_vld[DLY-1] || r_dly_oob[DLY-1] || w_barrier) begin
            w_red   = 8'd0;
            w_green = 8'd0;
            w_blue  = 8'd0;
        end else if (r_dly_ov[DLY-1]) begin
            w_red   = OVERLAY_R;
            w_green = OVERLAY_G;
            w_blue  = OVERLAY_B;
`ifdef DENSITY_GRID_LINES_EN
        end else if (w_grid) begin
            w_red   = GRID_LINE_LEVEL;
            w_green = GRID_LINE_LEVEL;
            w_blue  = GRID_LINE_LEVEL;
`endif
        end else begin
            case (r_mode)
                PACKED: begin
                    w_red   = {w_p12[11:8], 4'b0};
                    w_green = {w_p12[7:4], 4'b0};
                    w_blue  = {w_p12[3:0], 4'b0};
                end
                GRAY: begin
                    w_red   = w_t;
                    w_green = w_t;
                    w_blue  = w_t;
                end
                HEAT: begin
                    w_red   = w_t;
                    w_green = {w_fold[6:0], 1'b0};
                    w_blue  = ~w_t;
                end
                default: begin
                    w_red   = w_center;
                    w_green = w_center;
                    w_blue  = w_center;
                end
            endcase
        end
    end

    // Register the colour together with the aligned scan position
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            red_out    <= '0;
            green_out  <= '0;
            blue_out   <= '0;
            hcount_out <= '0;
            vcount_out <= '0;
        end else begin
            red_out    <= w_red;
            green_out  <= w_green;
            blue_out   <= w_blue;
            hcount_out <= r_dly_h[DLY-1];
            vcount_out <= r_dly_v[DLY-1];
        end
    end

endmodule

// File: tb/tb_density_renderer.sv
// Directed bench for density_renderer at default parameters. Each driven
// pixel pushes its expected colour and position into a queue; the entry is
// popped and compared when the pixel leaves the pipeline. data_in is fed
// three cycles after the pixel, matching a two-cycle memory behind addr_out.
module tb_density_renderer;
    import density_pkg::*;

    logic        clk = 1'b0;
    logic        rst_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic [1:0]  mode_in;
    logic        overlay_in;
    logic [71:0] data_in;
    logic [14:0] addr_out;
    logic [7:0]  red_out;
    logic [7:0]  green_out;
    logic [7:0]  blue_out;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;

    int checks = 0;
    int errors = 0;

    logic [44:0] exp_q[$];   // {r, g, b, h, v}
    logic [71:0] tap_q[$];   // taps waiting to be presented on data_in
    logic [1:0]  model_mode;

    // Clock
    always #5 clk = ~clk;

    density_renderer dut (
        .pixel_clk_in (clk),
        .rst_in       (rst_in),
        .hcount_in    (hcount_in),
        .vcount_in    (vcount_in),
        .mode_in      (mode_in),
        .overlay_in   (overlay_in),
        .data_in      (data_in),
        .addr_out     (addr_out),
        .red_out      (red_out),
        .green_out    (green_out),
        .blue_out     (blue_out),
        .hcount_out   (hcount_out),
        .vcount_out   (vcount_out)
    );

    function automatic logic [71:0] fill(input logic [7:0] val);
        return {9{val}};
    endfunction

    function automatic logic [71:0] rand_taps();
        logic [71:0] t;
        for (int i = 0; i < 9; i++) t[i*8 +: 8] = 8'($urandom_range(0, 254));
        return t;
    endfunction

    // Reference colour for one pixel
    function automatic logic [23:0] model_rgb(input logic [71:0] taps, input logic [1:0] mode,
                                              input logic ov, input logic oob,
                                              input logic [10:0] h, input logic [9:0] v);
        int         sum;
        logic       all_full;
        logic [7:0] tap;
        logic [7:0] t;
        int         f;
        sum = 0;
        all_full = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tap = taps[i*8 +: 8];
            sum += int'(tap);
            if (tap != 8'hFF) all_full = 1'b0;
        end
        t = 8'(sum / 16);
        if (oob || all_full) return 24'h0;
        if (ov) return {8'd219, 8'd48, 8'd130};
`ifdef DENSITY_GRID_LINES_EN
        if ((int'(h) % 4 == 0) || (int'(v) % 4 == 0)) return {8'd64, 8'd64, 8'd64};
`endif
        case (mode)
            2'd0: return {8'(((sum / 256) % 16) * 16), 8'(((sum / 16) % 16) * 16), 8'((sum % 16) * 16)};
            2'd1: return {t, t, t};
            2'd2: begin
                f = (int'(t) >= 128) ? (255 - int'(t)) : int'(t);
                return {t, 8'(f * 2), 8'(255 - int'(t))};
            end
            default: return {taps[39:32], taps[39:32], taps[39:32]};
        endcase
    endfunction

    // Drive one pixel for one cycle, then check addr_out and the pixel
    // that is leaving the pipeline
    task automatic step(input logic [10:0] h, input logic [9:0] v, input logic ov,
                        input logic [71:0] taps, input logic chk_addr);
        logic        oob;
        logic [14:0] ea;
        logic [44:0] e;
        @(negedge clk);
        hcount_in  = h;
        vcount_in  = v;
        overlay_in = ov;
        tap_q.push_back(taps);
        data_in = tap_q.pop_front();
        oob = (int'(h) / 4 >= 205) || (int'(v) / 4 >= 155);
        if (rst_in) begin
            ea = 15'd0;
            exp_q.delete();
            repeat (4) exp_q.push_back('0);
            model_mode = 2'd0;
        end else begin
            if (h == 11'd0 && v == 10'd0) model_mode = mode_in;
            ea = oob ? 15'd0 : 15'(int'(h) / 4 + (int'(v) / 4) * 205);
            exp_q.push_back({model_rgb(taps, model_mode, ov, oob, h, v), h, v});
        end
        @(posedge clk);
        #1;
        if (chk_addr) begin
            checks++;
            assert (addr_out === ea) else begin
                errors++;
                $error("FAIL addr pixel(%0d,%0d) got %0d want %0d", h, v, addr_out, ea);
            end
        end
        e = exp_q.pop_front();
        checks++;
        assert ({red_out, green_out, blue_out} === e[44:21]) else begin
            errors++;
            $error("FAIL rgb pixel(%0d,%0d) got %0d,%0d,%0d want %0d,%0d,%0d",
                   e[20:10], e[9:0], red_out, green_out, blue_out, e[44:37], e[36:29], e[28:21]);
        end
        checks++;
        assert ({hcount_out, vcount_out} === e[20:0]) else begin
            errors++;
            $error("FAIL counts got %0d,%0d want %0d,%0d", hcount_out, vcount_out, e[20:10], e[9:0]);
        end
    endtask

    // Out-of-bounds filler pixels: always black, address 0
    task automatic flush(input int n);
        repeat (n) step(11'd1000, 10'd1000, 1'b0, rand_taps(), 1'b1);
    endtask

    logic [71:0] one_zero;

    initial begin
        rst_in     = 1'b1;
        hcount_in  = '0;
        vcount_in  = '0;
        mode_in    = 2'd0;
        overlay_in = 1'b0;
        data_in    = '0;
        model_mode = 2'd0;
        one_zero   = {9{8'hFF}};
        one_zero[31:24] = 8'h00;
        repeat (3) tap_q.push_back('0);

        // Reset state
        repeat (3) step(11'd0, 10'd0, 1'b0, '0, 1'b1);
        rst_in = 1'b0;

        // PACKED frame: walk row starts down to row 12, then pixel (8,12)
        mode_in = PACKED;
        for (int v = 0; v <= 12; v++) step(11'd0, 10'(v), 1'b0, fill(8'd10), 1'b1);
        step(11'd8, 10'd12, 1'b0, fill(8'd10), 1'b1);
        for (int i = 0; i < 6; i++) step(11'($urandom_range(1, 819)), 10'd12, 1'b0, rand_taps(), 1'b1);

        // Barrier beats overlay; overlay on an empty cell
        step(11'd20, 10'd12, 1'b0, fill(8'd255), 1'b1);
        step(11'd21, 10'd12, 1'b1, fill(8'd255), 1'b1);
        step(11'd22, 10'd12, 1'b1, fill(8'd0), 1'b1);

        // Out-of-bounds pixels
        step(11'd820, 10'd0, 1'b0, rand_taps(), 1'b1);
        step(11'd0, 10'd620, 1'b0, rand_taps(), 1'b1);

        // Mode request mid-frame must not take effect yet
        mode_in = HEAT;
        step(11'd30, 10'd12, 1'b0, fill(8'd10), 1'b0);
        step(11'd31, 10'd12, 1'b0, one_zero, 1'b0);
        flush(2);

        // HEAT frame
        step(11'd0, 10'd0, 1'b0, fill(8'd10), 1'b1);
        step(11'd0, 10'd1, 1'b0, one_zero, 1'b1);
        for (int i = 0; i < 4; i++) step(11'($urandom_range(1, 819)), 10'd1, 1'b0, rand_taps(), 1'b1);
        flush(2);

        // GRAY frame
        mode_in = GRAY;
        step(11'd0, 10'd0, 1'b0, rand_taps(), 1'b1);
        for (int i = 0; i < 4; i++) step(11'($urandom_range(1, 819)), 10'd0, 1'b0, rand_taps(), 1'b1);
        flush(2);

        // CENTER frame
        mode_in = CENTER;
        step(11'd0, 10'd0, 1'b0, rand_taps(), 1'b1);
        for (int i = 0; i < 4; i++) step(11'($urandom_range(1, 819)), 10'd0, 1'b0, rand_taps(), 1'b1);
        flush(2);

        // PACKED frame interrupted by reset at (400,300)
        mode_in = PACKED;
        step(11'd0, 10'd0, 1'b0, fill(8'd10), 1'b1);
        step(11'd396, 10'd300, 1'b0, rand_taps(), 1'b0);
        rst_in = 1'b1;
        step(11'd400, 10'd300, 1'b0, rand_taps(), 1'b1);
        rst_in = 1'b0;
        for (int i = 1; i <= 6; i++) step(11'(400 + i), 10'd300, 1'b0, rand_taps(), 1'b0);
        flush(2);

        // Next frame addresses correctly again
        for (int v = 0; v <= 4; v++) step(11'd0, 10'(v), 1'b0, fill(8'd10), 1'b1);
        step(11'd5, 10'd4, 1'b0, fill(8'd10), 1'b1);

        // Cell-edge pixel vs interior pixel (grid lines only when enabled)
        step(11'd4, 10'd5, 1'b0, fill(8'd10), 1'b1);
        step(11'd5, 10'd5, 1'b0, fill(8'd10), 1'b1);
        flush(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
